// File: rtl/fight_match_controller.sv
// fight_match_controller
// Round/match sequencer for the two-player fighting datapath. Holds the
// player blocks in reset between matches and at each round start, gates raw
// controller moves so they only act during live play, detects KO / timeout
// from the players' health outputs and keeps round, win and winner state.
//
// Ports
//   clk, rst                      clock, async active-high reset
//   start                         level; sampled in IDLE and MATCH_OVER only
//   left/right_raw_input  [5:0]   one-hot moves {MR,ML,WAIT,JUMP,KICK,PUNCH}
//   left/right_health     [2:0]   players' registered health
//   left/right_player_input [5:0] gated moves to the player blocks
//   player_rst_n                  registered active-low reset to both players
//   state                 [2:0]   IDLE=0 ROUND_INIT=1 FIGHT=2 ROUND_END=3 MATCH_OVER=4
//   round_num             [1:0]   rounds completed
//   left_wins/right_wins  [1:0]   round wins (saturating)
//   round_timer           [7:0]   remaining FIGHT cycles
//   round_result          [1:0]   0 none, 1 left, 2 right, 3 draw
//   match_winner          [1:0]   same encoding, non-zero only in MATCH_OVER
module fight_match_controller #(
  parameter int ROUND_CYCLES  = 30,
  parameter int WINS_TO_MATCH = 2,
  parameter int MAX_ROUNDS    = 3,
  parameter int END_HOLD      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] left_raw_input,
  input  logic [5:0] right_raw_input,
  input  logic [2:0] left_health,
  input  logic [2:0] right_health,
  output logic [5:0] left_player_input,
  output logic [5:0] right_player_input,
  output logic       player_rst_n,
  output logic [2:0] state,
  output logic [1:0] round_num,
  output logic [1:0] left_wins,
  output logic [1:0] right_wins,
  output logic [7:0] round_timer,
  output logic [1:0] round_result,
  output logic [1:0] match_winner
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_FIGHT = 3'd2,
    S_END   = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic [7:0] LP_ROUND_CYC = 8'(ROUND_CYCLES);
  localparam logic [7:0] LP_HOLD_LAST = 8'(END_HOLD - 1);
  localparam logic [1:0] LP_WINS      = 2'(WINS_TO_MATCH);
  localparam logic [1:0] LP_MAX_RND   = 2'(MAX_ROUNDS);
  localparam logic [5:0] LP_WAIT      = 6'b001000;

  state_t     r_state, w_next;
  logic [7:0] r_cnt;          // cycles spent in the current state
  logic       r_player_rst_n;
  logic [1:0] r_round_num, r_left_wins, r_right_wins, r_round_result;
  logic [7:0] r_round_timer;

  logic       w_left_ko, w_right_ko, w_round_over, w_start_match, w_match_done;
  logic [1:0] w_result;

  // Health 6/7 only appears when a hit underflows 3-bit health, so treat it as 0.
  assign w_left_ko  = (left_health  == 3'd0) || (left_health  >= 3'd6);
  assign w_right_ko = (right_health == 3'd0) || (right_health >= 3'd6);

  assign w_round_over  = (r_state == S_FIGHT) &&
                         (w_left_ko || w_right_ko || (r_round_timer == 8'd1));
  assign w_start_match = start && ((r_state == S_IDLE) || (r_state == S_OVER));
  assign w_match_done  = (r_left_wins == LP_WINS) || (r_right_wins == LP_WINS) ||
                         (r_round_num == LP_MAX_RND);

  // KO beats timeout, so a KO on the final cycle is still scored as a KO.
  always_comb begin
    w_result = 2'd3;
    if (w_left_ko && w_right_ko)        w_result = 2'd3;
    else if (w_left_ko)                 w_result = 2'd2;
    else if (w_right_ko)                w_result = 2'd1;
    else if (left_health > right_health) w_result = 2'd1;
    else if (right_health > left_health) w_result = 2'd2;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_INIT;
      S_INIT:  if (r_cnt == 8'd1) w_next = S_FIGHT;
      S_FIGHT: if (w_round_over) w_next = S_END;
      S_END:   if (r_cnt == LP_HOLD_LAST) w_next = w_match_done ? S_OVER : S_INIT;
      S_OVER:  if (start) w_next = S_INIT;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? 8'd0 : r_cnt + 8'd1;
    end
  end

  // Players are held in reset in IDLE and on the first ROUND_INIT cycle only;
  // releasing on the second cycle lets their health settle before FIGHT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_player_rst_n <= 1'b0;
    else     r_player_rst_n <= !((w_next == S_IDLE) ||
                                 ((w_next == S_INIT) && (r_state != S_INIT)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_round_timer <= 8'd0;
    end else if ((r_state == S_INIT) && (w_next == S_FIGHT)) begin
      r_round_timer <= LP_ROUND_CYC;
    end else if (r_state == S_FIGHT) begin
      r_round_timer <= r_round_timer - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_round_num    <= 2'd0;
      r_left_wins    <= 2'd0;
      r_right_wins   <= 2'd0;
      r_round_result <= 2'd0;
    end else if (w_start_match) begin
      r_round_num    <= 2'd0;
      r_left_wins    <= 2'd0;
      r_right_wins   <= 2'd0;
      r_round_result <= 2'd0;
    end else if (w_round_over) begin
      r_round_result <= w_result;
      if (r_round_num != 2'd3) r_round_num <= r_round_num + 2'd1;
      if ((w_result == 2'd1) && (r_left_wins  != 2'd3)) r_left_wins  <= r_left_wins  + 2'd1;
      if ((w_result == 2'd2) && (r_right_wins != 2'd3)) r_right_wins <= r_right_wins + 2'd1;
    end
  end

  // WAIT is dropped at health >= 5 so regen cannot wrap 3-bit health.
  function automatic logic [5:0] gate_move(input logic [5:0] raw, input logic [2:0] hp,
                                           input logic live);
    logic one_hot;
    one_hot = (raw != 6'd0) && ((raw & (raw - 6'd1)) == 6'd0);
    if (!live || !one_hot)                return 6'd0;
    if ((raw == LP_WAIT) && (hp >= 3'd5)) return 6'd0;
    return raw;
  endfunction

  assign left_player_input  = gate_move(left_raw_input,  left_health,  r_state == S_FIGHT);
  assign right_player_input = gate_move(right_raw_input, right_health, r_state == S_FIGHT);

  always_comb begin
    match_winner = 2'd0;
    if (r_state == S_OVER) begin
      if (r_left_wins > r_right_wins)      match_winner = 2'd1;
      else if (r_right_wins > r_left_wins) match_winner = 2'd2;
      else                                 match_winner = 2'd3;
    end
  end

  assign state        = r_state;
  assign player_rst_n = r_player_rst_n;
  assign round_num    = r_round_num;
  assign left_wins    = r_left_wins;
  assign right_wins   = r_right_wins;
  assign round_timer  = r_round_timer;
  assign round_result = r_round_result;

endmodule

// File: tb/tb_fight_match_controller.sv
// Self-checking bench for fight_match_controller: directed scenarios with
// literal expectations, then randomized play, all compared every cycle
// against a behavioural match model.
module tb_fight_match_controller;
  localparam int RC = 30, WTM = 2, MR = 3, EH = 4;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [5:0] lri = 6'd0, rri = 6'd0;
  logic [2:0] lh = 3'd3, rh = 3'd3;
  logic [5:0] lpi, rpi;
  logic       prst_n;
  logic [2:0] st;
  logic [1:0] rn, lw, rw, res, mw;
  logic [7:0] tmr;

  int checks = 0, errors = 0;

  fight_match_controller #(.ROUND_CYCLES(RC), .WINS_TO_MATCH(WTM), .MAX_ROUNDS(MR),
                           .END_HOLD(EH)) dut (
    .clk(clk), .rst(rst), .start(start),
    .left_raw_input(lri), .right_raw_input(rri),
    .left_health(lh), .right_health(rh),
    .left_player_input(lpi), .right_player_input(rpi),
    .player_rst_n(prst_n), .state(st), .round_num(rn),
    .left_wins(lw), .right_wins(rw), .round_timer(tmr),
    .round_result(res), .match_winner(mw)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase numbering follows the output encoding; m_cyc counts cycles in phase.
  int m_st = 0, m_cyc = 0, m_round = 0, m_lw = 0, m_rw = 0, m_res = 0;

  function automatic bit is_ko(input int h);
    return (h == 0) || (h >= 6);
  endfunction

  function automatic int gate(input int raw, input int h, input bit live);
    if (!live) return 0;
    if ($countones(raw[5:0]) != 1) return 0;
    if (raw == 8 && h >= 5) return 0;
    return raw;
  endfunction

  function automatic int winner_of(input int a, input int b);
    if (a > b) return 1;
    if (b > a) return 2;
    return 3;
  endfunction

  task automatic model_clear();
    m_round = 0; m_lw = 0; m_rw = 0; m_res = 0;
  endtask

  task automatic model_step();
    bit lk, rk;
    int w;
    case (m_st)
      0: if (start) begin m_st = 1; m_cyc = 0; model_clear(); end else m_cyc++;
      1: if (m_cyc == 1) begin m_st = 2; m_cyc = 0; end else m_cyc++;
      2: begin
        lk = is_ko(lh); rk = is_ko(rh);
        if (lk || rk || m_cyc == RC - 1) begin
          if (lk && rk) w = 3;
          else if (lk)  w = 2;
          else if (rk)  w = 1;
          else          w = winner_of(lh, rh);
          m_res = w;
          if (w == 1 && m_lw < 3) m_lw++;
          if (w == 2 && m_rw < 3) m_rw++;
          if (m_round < 3) m_round++;
          m_st = 3; m_cyc = 0;
        end else m_cyc++;
      end
      3: if (m_cyc == EH - 1) begin
        m_st = (m_lw == WTM || m_rw == WTM || m_round == MR) ? 4 : 1;
        m_cyc = 0;
      end else m_cyc++;
      default: if (start) begin m_st = 1; m_cyc = 0; model_clear(); end
    endcase
  endtask

  // Compare process: outputs sampled on the falling edge, then the model
  // advances with the inputs the DUT will see on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin m_st = 0; m_cyc = 0; model_clear(); end
    chk("state", st, m_st);
    chk("player_rst_n", prst_n, (m_st == 0 || (m_st == 1 && m_cyc == 0)) ? 0 : 1);
    chk("round_num", rn, m_round);
    chk("left_wins", lw, m_lw);
    chk("right_wins", rw, m_rw);
    chk("round_result", res, m_res);
    chk("match_winner", mw, (m_st == 4) ? winner_of(m_lw, m_rw) : 0);
    chk("left_player_input", lpi, gate(lri, lh, m_st == 2));
    chk("right_player_input", rpi, gate(rri, rh, m_st == 2));
    if (m_st == 2) chk("round_timer", tmr, RC - m_cyc);
    if (rst) chk("round_timer_rst", tmr, 0);
    if (!rst) model_step();
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic ko_right();
    rh = 3'd0; step(1); rh = 3'd3;
  endtask

  initial begin
    // reset with junk on the raw inputs
    lri = 6'b000001; rri = 6'b100000;
    step(3);
    chk("lit_rst_state", st, 0);      chk("lit_rst_prst", prst_n, 0);
    chk("lit_rst_rn", rn, 0);         chk("lit_rst_lw", lw, 0);
    chk("lit_rst_tmr", tmr, 0);       chk("lit_rst_res", res, 0);
    chk("lit_rst_mw", mw, 0);         chk("lit_rst_lpi", lpi, 0);
    rst = 1'b0; lri = 6'd0; rri = 6'd0;
    step(1);

    // round start sequence
    start = 1'b1; step(1);
    chk("lit_init1_state", st, 1); chk("lit_init1_prst", prst_n, 0);
    start = 1'b0; step(1);
    chk("lit_init2_state", st, 1); chk("lit_init2_prst", prst_n, 1);
    step(1);
    chk("lit_fight_state", st, 2); chk("lit_fight_tmr", tmr, 30);

    // input filtering in FIGHT
    lri = 6'b000011; rri = 6'b001000; rh = 3'd5; #1;
    chk("lit_multi_hot", lpi, 0); chk("lit_wait_h5", rpi, 0);
    rh = 3'd4; lri = 6'b010000; #1;
    chk("lit_wait_h4", rpi, 8); chk("lit_move_left", lpi, 16);
    rh = 3'd3;

    // left wins by KO
    step(3); ko_right();
    chk("lit_ko_state", st, 3); chk("lit_ko_res", res, 1);
    chk("lit_ko_lw", lw, 1);    chk("lit_ko_rn", rn, 1);
    chk("lit_ko_gated", lpi, 0);
    step(3); chk("lit_hold_state", st, 3);
    step(1); chk("lit_reinit_state", st, 1);
    step(2); ko_right(); step(4);
    chk("lit_match_state", st, 4); chk("lit_match_mw", mw, 1);
    chk("lit_match_rn", rn, 2);    chk("lit_match_lw", lw, 2);
    lri = 6'd0; rri = 6'd0;

    // restart clears counters
    start = 1'b1; step(1); start = 1'b0;
    chk("lit_restart_state", st, 1); chk("lit_restart_rn", rn, 0);
    chk("lit_restart_lw", lw, 0);    chk("lit_restart_res", res, 0);
    chk("lit_restart_mw", mw, 0);

    // timeout 3 vs 2, then 3 vs 3
    step(2); rh = 3'd2; step(29);
    chk("lit_to_last_state", st, 2); chk("lit_to_last_tmr", tmr, 1);
    step(1);
    chk("lit_to_state", st, 3); chk("lit_to_res", res, 1); chk("lit_to_lw", lw, 1);
    step(4); step(2); rh = 3'd3; step(30);
    chk("lit_todraw_res", res, 3); chk("lit_todraw_lw", lw, 1);
    chk("lit_todraw_rw", rw, 0);   chk("lit_todraw_rn", rn, 2);
    step(4); step(2); lh = 3'd0; rh = 3'd0; step(1); lh = 3'd3; rh = 3'd3;
    chk("lit_dko_res", res, 3); chk("lit_dko_rn", rn, 3);
    step(4); chk("lit_maxr_state", st, 4); chk("lit_maxr_mw", mw, 1);

    // three double-KO draws
    start = 1'b1; step(1); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(2); lh = 3'd0; rh = 3'd0; step(1); lh = 3'd3; rh = 3'd3;
      chk("lit_draw_res", res, 3);
      step(4);
    end
    chk("lit_draws_state", st, 4); chk("lit_draws_mw", mw, 3); chk("lit_draws_rn", rn, 3);

    // start held across MATCH_OVER re-arms once
    start = 1'b1; step(1); chk("lit_held_init", st, 1);
    step(3); chk("lit_held_fight", st, 2);
    start = 1'b0;

    // reset mid-round
    rst = 1'b1; #1;
    chk("lit_midrst_state", st, 0); chk("lit_midrst_prst", prst_n, 0);
    chk("lit_midrst_tmr", tmr, 0);
    step(1); rst = 1'b0;

    // randomized play
    for (int c = 0; c < 4000; c++) begin
      int r;
      start = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 599) == 0);
      for (int p = 0; p < 2; p++) begin
        logic [5:0] mv;
        logic [2:0] hp;
        r = $urandom_range(0, 3);
        case (r)
          0: mv = 6'd0;
          1: mv = 6'd1 << $urandom_range(0, 5);
          2: mv = 6'($urandom_range(0, 63));
          default: mv = 6'b001000;
        endcase
        if ($urandom_range(0, 59) == 0) hp = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'(5 + $urandom_range(1, 2));
        else hp = 3'($urandom_range(1, 5));
        if (p == 0) begin lri = mv; lh = hp; end
        else        begin rri = mv; rh = hp; end
      end
      step(1);
    end
    rst = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fight_match_controller.md
# fight_match_controller

Round and match sequencer for the two-player fighting datapath. Sits between the raw controller inputs and the left/right player blocks: resets the players at each round start, gates their move inputs so moves only act during live play, detects knock-outs and timeouts from the players' health outputs, and keeps round, win and match-winner state.

## Interface

- ROUND_CYCLES, 30: live FIGHT cycles per round before timeout.
- WINS_TO_MATCH, 2: round wins needed to take the match.
- MAX_ROUNDS, 3: round limit; match ends when reached.
- END_HOLD, 4: cycles spent in ROUND_END.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level, sampled in IDLE and MATCH_OVER only.
- left_raw_input, right_raw_input  in  6  one-hot moves {MOVE_RIGHT,MOVE_LEFT,WAIT,JUMP,KICK,PUNCH} = bits 5..0; 0 = idle.
- left_health, right_health  in  3  players' registered health outputs.
- left_player_input, right_player_input  out  6  gated moves to the player blocks.
- player_rst_n  out  1  active-low reset to both player blocks (registered).
- state  out  3  IDLE=0, ROUND_INIT=1, FIGHT=2, ROUND_END=3, MATCH_OVER=4.
- round_num  out  2  rounds completed.
- left_wins, right_wins  out  2  round wins.
- round_timer  out  8  remaining FIGHT cycles.
- round_result  out  2  last round: 0 none, 1 left, 2 right, 3 draw.
- match_winner  out  2  same encoding; valid in MATCH_OVER, else 0.

## Operation

- IDLE: player_rst_n=0, gated outputs 0. start=1 -> ROUND_INIT; clears round_num, wins, round_result.
- ROUND_INIT: exactly 2 cycles. Cycle 1 player_rst_n=0; cycle 2 player_rst_n=1, outputs 0 (lets player health_out settle to 3). Loads round_timer=ROUND_CYCLES, then -> FIGHT.
- FIGHT: raw inputs pass through, with filtering: non-one-hot raw value -> 0; WAIT -> 0 when that player's health >= 5 (caps regen below wrap). round_timer decrements each cycle.
- KO: health value 0, 6 or 7 (6/7 = subtraction underflow) counts as KO.
- Round end checks, each FIGHT cycle, priority order: both KO -> draw; one KO -> other wins; round_timer==1 -> timeout: higher health wins, equal -> draw. On any: round_result updated, winner's wins++ (saturating at 3), round_num++, -> ROUND_END.
- ROUND_END: outputs 0, player_rst_n=1, hold END_HOLD cycles. Then -> MATCH_OVER if either wins==WINS_TO_MATCH or round_num==MAX_ROUNDS, else -> ROUND_INIT.
- MATCH_OVER: match_winner = player with more wins, equal -> 3. Outputs 0, player_rst_n=1 (final health visible). start=1 -> ROUND_INIT with counters cleared, as from IDLE.

## Timing

- Reset values: state=IDLE, player_rst_n=0, round_num=0, wins=0, round_timer=0, round_result=0, match_winner=0; gated outputs 0.
- Gated outputs are combinational from state and raw inputs; zero latency in FIGHT.
- KO visible on health input in cycle t -> state=ROUND_END at t+1; outputs 0 from t+1.
- Timeout: FIGHT lasts exactly ROUND_CYCLES cycles if no KO; KO on the last cycle is scored as KO, not timeout.
- start held high across MATCH_OVER -> ROUND_INIT re-arms once; ignored in other states.
- rst mid-round: immediate return to reset values; players held in reset via player_rst_n.

## Test plan

- Reset, start=1 one cycle -> ROUND_INIT 2 cycles (player_rst_n 0 then 1), FIGHT at cycle 3, round_timer=30.
- FIGHT, right_health drops to 0 at cycle t -> ROUND_END at t+1, round_result=1, left_wins=1, round_num=1; after 4 cycles ROUND_INIT.
- Left wins two rounds by KO -> MATCH_OVER, match_winner=1, round_num=2; start -> counters cleared.
- 30 FIGHT cycles, health 3 vs 2 -> timeout, round_result=1; health 3 vs 3 -> round_result=3, no wins change.
- Both health 0 same cycle -> draw; three draws -> MATCH_OVER at MAX_ROUNDS, match_winner=3.
- Outside FIGHT any raw input -> gated 0; in FIGHT raw 6'b000011 -> 0, WAIT with health 5 -> 0, WAIT with health 4 -> 6'b001000.
